alu8_nzvc_reg: RTL and testbench

Registered 8-bit (parameterisable) integer ALU.
- Eight operations: add, increment, subtract, decrement, AND, OR, XOR, NOT.
- Produces a result plus a 4-bit condition code NZVC.
- Sits in the datapath between operand registers and the flag/writeback stage.
- One-cycle latency with a simple valid qualifier.

---
 rtl/alu8_nzvc_reg.sv | 119 +++++++++++
 tb/tb_alu8_nzvc_reg.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu8_nzvc_reg.sv
// Registered WIDTH-bit ALU: eight operations, result plus NZVC flags, one-cycle latency.
// Optional build macro ALU_SAT_EN saturates ADD/INC/SUB/DEC results on signed overflow.
module alu8_nzvc_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alu_sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       nzvc
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

`ifdef ALU_SAT_EN
  function automatic logic signed [WIDTH-1:0] sat_fn(input logic signed [WIDTH-1:0] wrapped,
                                                     input logic                     ovf);
    logic signed [WIDTH-1:0] s_max;
    logic signed [WIDTH-1:0] s_min;
    s_max = {1'b0, {(WIDTH-1){1'b1}}};
    s_min = {1'b1, {(WIDTH-1){1'b0}}};
    if (!ovf) return wrapped;
    // On overflow the wrapped sign is the opposite of the true sign.
    return wrapped[WIDTH-1] ? s_max : s_min;
  endfunction
`endif

  logic [1:0]       rst_sync;
  logic             run;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic [WIDTH-1:0] wrap;
  logic [WIDTH-1:0] res_c;
  logic             is_add;
  logic             is_sub;
  logic             decoded;
  logic             v_c;
  logic             c_c;
  logic [3:0]       nzvc_c;
  logic [WIDTH-1:0] result_p1;
  logic [3:0]       nzvc_p1;
  logic             vld_p1;

  // Assertion is immediate; release reaches the capture logic two edges later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign run = rst_sync[1];

  always_comb begin
    opnd    = b;
    is_add  = 1'b0;
    is_sub  = 1'b0;
    decoded = 1'b1;
    res_c   = '0;
    v_c     = 1'b0;
    c_c     = 1'b0;
    case (alu_sel)
      3'd0: is_add = 1'b1;
      3'd1: begin is_add = 1'b1; opnd = ONE; end
      3'd2: is_sub = 1'b1;
      3'd3: begin is_sub = 1'b1; opnd = ONE; end
      3'd4: res_c = a & b;
      3'd5: res_c = a | b;
      3'd6: res_c = a ^ b;
      3'd7: res_c = ~a;
      default: decoded = 1'b0;
    endcase

    sum_ext  = {1'b0, a} + {1'b0, opnd};
    diff_ext = {1'b0, a} - {1'b0, opnd};
    wrap     = is_sub ? diff_ext[WIDTH-1:0] : sum_ext[WIDTH-1:0];

    if (is_add) begin
      v_c = (a[WIDTH-1] == opnd[WIDTH-1]) && (wrap[WIDTH-1] != a[WIDTH-1]);
      c_c = sum_ext[WIDTH];
    end
    if (is_sub) begin
      v_c = (a[WIDTH-1] != opnd[WIDTH-1]) && (wrap[WIDTH-1] != a[WIDTH-1]);
      c_c = diff_ext[WIDTH];
    end
    if (is_add || is_sub) begin
`ifdef ALU_SAT_EN
      res_c = sat_fn(wrap, v_c);
`else
      res_c = wrap;
`endif
    end

    nzvc_c = decoded ? {res_c[WIDTH-1], (res_c == '0), v_c, c_c} : 4'b0000;
  end

  // Stage p1: registered result, flags and valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_p1 <= '0;
      nzvc_p1   <= 4'b0000;
      vld_p1    <= 1'b0;
    end else begin
      vld_p1 <= in_valid && run;
      if (in_valid && run) begin
        result_p1 <= res_c;
        nzvc_p1   <= nzvc_c;
      end
    end
  end

  assign out_valid = vld_p1;
  assign result    = result_p1;
  assign nzvc      = nzvc_p1;

endmodule

// File: tb/tb_alu8_nzvc_reg.sv
// Self-checking bench for alu8_nzvc_reg: directed boundary vectors plus randomized streaming.
module tb_alu8_nzvc_reg;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic [2:0] alu_sel = 3'd0;
  logic       out_valid;
  logic [7:0] result;
  logic [3:0] nzvc;

  int tests = 0;
  int fails = 0;
  logic [7:0] hold_r = 8'h00;
  logic [3:0] hold_f = 4'b0000;

  always #5 clk = ~clk;

  alu8_nzvc_reg #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
    .alu_sel(alu_sel), .out_valid(out_valid), .result(result), .nzvc(nzvc)
  );

  // Reference: evaluate the operation on integers, then derive flags from value ranges.
  function automatic void model(input int op, input int av, input int bv,
                                output logic [7:0] r, output logic [3:0] f);
    int opb, sa, sb, s, u;
    logic v, c;
    v = 1'b0; c = 1'b0; s = 0; u = 0;
    opb = (op == 1 || op == 3) ? 1 : bv;
    sa = (av > 127) ? av - 256 : av;
    sb = (opb > 127) ? opb - 256 : opb;
    case (op)
      0, 1: begin u = av + opb; s = sa + sb; c = (u > 255); end
      2, 3: begin u = av - opb; s = sa - sb; c = (av < opb); end
      4: u = av & bv;
      5: u = av | bv;
      6: u = av ^ bv;
      default: u = 255 - av;
    endcase
    r = u[7:0];
    if (op < 4) begin
      v = (s > 127) || (s < -128);
`ifdef ALU_SAT_EN
      if (v) r = (s > 127) ? 8'h7F : 8'h80;
`endif
    end
    f = {r[7], (r == 8'h00), v, c};
  endfunction

  task automatic drive(input logic v, input logic [2:0] op, input logic [7:0] av, input logic [7:0] bv);
    in_valid = v; alu_sel = op; a = av; b = bv;
    @(posedge clk); #1;
  endtask

  task automatic release_reset();
    in_valid = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || result !== 8'h00 || nzvc !== 4'b0000) begin
      fails++;
      $display("FAIL reset_async: got v=%b r=%h f=%b, want v=0 r=00 f=0000", out_valid, result, nzvc);
    end
    drive(1'b1, 3'd0, 8'h12, 8'h34);
    drive(1'b1, 3'd7, 8'h00, 8'h00);
    tests++;
    if (out_valid !== 1'b0 || result !== 8'h00 || nzvc !== 4'b0000) begin
      fails++;
      $display("FAIL reset_held: got v=%b r=%h f=%b, want v=0 r=00 f=0000", out_valid, result, nzvc);
    end
    release_reset();
    tests++;
    if (out_valid !== 1'b0 || result !== 8'h00 || nzvc !== 4'b0000) begin
      fails++;
      $display("FAIL reset_release: got v=%b r=%h f=%b, want v=0 r=00 f=0000", out_valid, result, nzvc);
    end
    hold_r = 8'h00; hold_f = 4'b0000;
  endtask

  task automatic test_add();
    logic [7:0] ta[0:2], tb[0:2], er[0:2];
    logic [3:0] ef[0:2];
    ta = '{8'h01, 8'h64, 8'h64};
    tb = '{8'h05, 8'h1E, 8'h88};
`ifdef ALU_SAT_EN
    er = '{8'h06, 8'h7F, 8'hEC};
    ef = '{4'b0000, 4'b0010, 4'b1000};
`else
    er = '{8'h06, 8'h82, 8'hEC};
    ef = '{4'b0000, 4'b1010, 4'b1000};
`endif
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'd0, ta[i], tb[i]);
      tests++;
      if (out_valid !== 1'b1 || result !== er[i] || nzvc !== ef[i]) begin
        fails++;
        $display("FAIL add[%0d]: got v=%b r=%h f=%b, want v=1 r=%h f=%b", i, out_valid, result, nzvc, er[i], ef[i]);
      end
      hold_r = er[i]; hold_f = ef[i];
    end
  endtask

  task automatic test_incdec();
    logic [2:0] to[0:4];
    logic [7:0] ta[0:4], er[0:4];
    logic [3:0] ef[0:4];
    to = '{3'd1, 3'd1, 3'd3, 3'd3, 3'd3};
    ta = '{8'h7F, 8'hFF, 8'h80, 8'h01, 8'h00};
`ifdef ALU_SAT_EN
    er = '{8'h7F, 8'h00, 8'h80, 8'h00, 8'hFF};
    ef = '{4'b0010, 4'b0101, 4'b1010, 4'b0100, 4'b1001};
`else
    er = '{8'h80, 8'h00, 8'h7F, 8'h00, 8'hFF};
    ef = '{4'b1010, 4'b0101, 4'b0010, 4'b0100, 4'b1001};
`endif
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, to[i], ta[i], 8'($urandom));
      tests++;
      if (out_valid !== 1'b1 || result !== er[i] || nzvc !== ef[i]) begin
        fails++;
        $display("FAIL incdec[%0d]: got v=%b r=%h f=%b, want v=1 r=%h f=%b", i, out_valid, result, nzvc, er[i], ef[i]);
      end
      hold_r = er[i]; hold_f = ef[i];
    end
  endtask

  task automatic test_sub();
    logic [7:0] ta[0:3], tb[0:3], er[0:3];
    logic [3:0] ef[0:3];
    ta = '{8'd17, 8'd73, 8'd73, 8'hF7};
    tb = '{8'd40, 8'd40, 8'hA3, 8'hA3};
`ifdef ALU_SAT_EN
    er = '{8'hE9, 8'h21, 8'h7F, 8'h54};
    ef = '{4'b1001, 4'b0000, 4'b0011, 4'b0000};
`else
    er = '{8'hE9, 8'h21, 8'hA6, 8'h54};
    ef = '{4'b1001, 4'b0000, 4'b1011, 4'b0000};
`endif
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 3'd2, ta[i], tb[i]);
      tests++;
      if (out_valid !== 1'b1 || result !== er[i] || nzvc !== ef[i]) begin
        fails++;
        $display("FAIL sub[%0d]: got v=%b r=%h f=%b, want v=1 r=%h f=%b", i, out_valid, result, nzvc, er[i], ef[i]);
      end
      hold_r = er[i]; hold_f = ef[i];
    end
  endtask

  task automatic test_logic();
    logic [2:0] to[0:3];
    logic [7:0] ta[0:3], tb[0:3], er[0:3];
    logic [3:0] ef[0:3];
    to = '{3'd4, 3'd5, 3'd6, 3'd7};
    ta = '{8'h4E, 8'h4E, 8'h00, 8'hFF};
    tb = '{8'h79, 8'h79, 8'hFF, 8'h5A};
    er = '{8'h48, 8'h7F, 8'hFF, 8'h00};
    ef = '{4'b0000, 4'b0000, 4'b1000, 4'b0100};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, to[i], ta[i], tb[i]);
      tests++;
      if (out_valid !== 1'b1 || result !== er[i] || nzvc !== ef[i]) begin
        fails++;
        $display("FAIL logic[%0d]: got v=%b r=%h f=%b, want v=1 r=%h f=%b", i, out_valid, result, nzvc, er[i], ef[i]);
      end
      hold_r = er[i]; hold_f = ef[i];
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] er, av, bv;
    logic [3:0] ef;
    logic [2:0] op;
    for (int i = 0; i < 4; i++) begin
      op = 3'(i * 2 + 1);
      av = 8'($urandom); bv = 8'($urandom);
      model(int'(op), int'(av), int'(bv), er, ef);
      drive(1'b1, op, av, bv);
      tests++;
      if (out_valid !== 1'b1 || result !== er || nzvc !== ef) begin
        fails++;
        $display("FAIL stream[%0d]: got v=%b r=%h f=%b, want v=1 r=%h f=%b", i, out_valid, result, nzvc, er, ef);
      end
      hold_r = er; hold_f = ef;
    end
    drive(1'b0, 3'd0, 8'($urandom), 8'($urandom));
    drive(1'b0, 3'd2, 8'($urandom), 8'($urandom));
    tests++;
    if (out_valid !== 1'b0 || result !== hold_r || nzvc !== hold_f) begin
      fails++;
      $display("FAIL hold: got v=%b r=%h f=%b, want v=0 r=%h f=%b", out_valid, result, nzvc, hold_r, hold_f);
    end
  endtask

  task automatic test_midstream_reset();
    drive(1'b1, 3'd0, 8'h64, 8'h1E);
    drive(1'b1, 3'd6, 8'hA5, 8'h0F);
    in_valid = 1'b1; alu_sel = 3'd2; a = 8'h33; b = 8'h11;
    #3 rst_n = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || result !== 8'h00 || nzvc !== 4'b0000) begin
      fails++;
      $display("FAIL midreset_async: got v=%b r=%h f=%b, want v=0 r=00 f=0000", out_valid, result, nzvc);
    end
    @(posedge clk); #1;
    tests++;
    if (out_valid !== 1'b0 || result !== 8'h00 || nzvc !== 4'b0000) begin
      fails++;
      $display("FAIL midreset_inflight: got v=%b r=%h f=%b, want v=0 r=00 f=0000", out_valid, result, nzvc);
    end
    release_reset();
    tests++;
    if (out_valid !== 1'b0 || result !== 8'h00 || nzvc !== 4'b0000) begin
      fails++;
      $display("FAIL midreset_release: got v=%b r=%h f=%b, want v=0 r=00 f=0000", out_valid, result, nzvc);
    end
    hold_r = 8'h00; hold_f = 4'b0000;
  endtask

  task automatic test_random();
    logic [7:0] er, av, bv;
    logic [3:0] ef;
    logic [2:0] op;
    logic       v;
    for (int i = 0; i < 400; i++) begin
      v  = ($urandom_range(0, 3) != 0);
      op = 3'($urandom_range(0, 7));
      av = 8'($urandom); bv = 8'($urandom);
      if (v) begin
        model(int'(op), int'(av), int'(bv), er, ef);
        hold_r = er; hold_f = ef;
      end
      drive(v, op, av, bv);
      tests++;
      if (out_valid !== v || result !== hold_r || nzvc !== hold_f) begin
        fails++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h: got v=%b r=%h f=%b, want v=%b r=%h f=%b",
                 i, op, av, bv, out_valid, result, nzvc, v, hold_r, hold_f);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_incdec();
    test_sub();
    test_logic();
    test_back_to_back();
    test_midstream_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
